// File: rtl/match_pkg.sv
// Shared encodings for the match controller slice: FSM states, winner codes, digit widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package match_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_HOLD = 2'b10,
      ST_OVER = 2'b11
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam int BCD_W    = 4;
   localparam int SHADOW_W = 7;

endpackage

// File: rtl/match_controller_if.sv
// Bundle between sensor/button logic (master) and the match controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface match_controller_if;
   import match_pkg::*;

   logic                start;
   logic                pause;
   logic                goal_a;
   logic                goal_b;
   logic                tick_1hz;
   logic [BCD_W-1:0]    score_a_ones;
   logic [BCD_W-1:0]    score_a_tens;
   logic [BCD_W-1:0]    score_b_ones;
   logic [BCD_W-1:0]    score_b_tens;
   logic [1:0]          state;
   logic [1:0]          winner;
   logic                goal_flash;
   logic                serve_side;
   logic [7:0]          time_left;

   modport master (
      output start, pause, goal_a, goal_b, tick_1hz,
      input  score_a_ones, score_a_tens, score_b_ones, score_b_tens,
      input  state, winner, goal_flash, serve_side, time_left
   );

   modport slave (
      input  start, pause, goal_a, goal_b, tick_1hz,
      output score_a_ones, score_a_tens, score_b_ones, score_b_tens,
      output state, winner, goal_flash, serve_side, time_left
   );

endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score with a binary shadow count used for the win compare.
// Latency: clear/inc take effect on the next clk edge.
// Backpressure: none; saturates at 99 so digits always stay legal BCD.
module bcd_score_counter
   import match_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                inc,
   output logic [BCD_W-1:0]    ones,
   output logic [BCD_W-1:0]    tens,
   output logic [SHADOW_W-1:0] count
);

   localparam logic [SHADOW_W-1:0] MAX_COUNT = SHADOW_W'(99);
   localparam logic [BCD_W-1:0]    DIGIT_MAX = BCD_W'(9);

   // Clear wins over increment; holding at 99 also keeps tens from passing 9.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones  <= '0;
         tens  <= '0;
         count <= '0;
      end else if (clear) begin
         ones  <= '0;
         tens  <= '0;
         count <= '0;
      end else if (inc && (count != MAX_COUNT)) begin
         count <= count + SHADOW_W'(1);
         if (ones == DIGIT_MAX) begin
            ones <= '0;
            tens <= tens + BCD_W'(1);
         end else begin
            ones <= ones + BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/match_controller.sv
// Two-player match sequencer: IDLE/PLAY/HOLD/OVER, goal arbitration, scores, winner; MATCH_TIMER_EN adds a countdown.
// Latency: input rising edges act on the same clk edge that first samples them high; outputs are registered.
// Backpressure: none; events arriving in states that cannot use them are dropped.
module match_controller
   import match_pkg::*;
#(
   parameter int WIN_SCORE     = 11,
   parameter int HOLD_CYCLES   = 100000000,
   parameter int MATCH_SECONDS = 90
) (
   input  logic              clk,
   input  logic              rst_n,
   match_controller_if.slave io
);

   localparam int                  HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SHADOW_W-1:0] WIN_CNT   = SHADOW_W'(WIN_SCORE);

   logic                start_q, goal_a_q, goal_b_q;
   logic                start_ev, goal_a_ev, goal_b_ev;
   state_t              state_q;
   logic [1:0]          winner_q;
   logic                flash_q, serve_q, prio_b_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic                play_live, start_acc, clear_scores;
   logic                both_ev, credit_a, credit_b, win_a, win_b;
   logic [SHADOW_W-1:0] count_a, count_b;
   logic                expire;
   logic [1:0]          time_winner;

   assign start_ev  = io.start  & ~start_q;
   assign goal_a_ev = io.goal_a & ~goal_a_q;
   assign goal_b_ev = io.goal_b & ~goal_b_q;

   // Goals only count in PLAY with pause low; a simultaneous pair goes to the priority holder.
   assign play_live = (state_q == ST_PLAY) & ~io.pause;
   assign both_ev   = play_live & goal_a_ev & goal_b_ev;
   assign credit_a  = play_live & goal_a_ev & (~goal_b_ev | ~prio_b_q);
   assign credit_b  = play_live & goal_b_ev & (~goal_a_ev |  prio_b_q);
   assign win_a     = credit_a & ((count_a + SHADOW_W'(1)) == WIN_CNT);
   assign win_b     = credit_b & ((count_b + SHADOW_W'(1)) == WIN_CNT);

   assign start_acc    = start_ev & ((state_q == ST_IDLE) | (state_q == ST_OVER));
   assign clear_scores = start_acc | (state_q == ST_IDLE);

`ifdef MATCH_TIMER_EN
   localparam logic [7:0] MATCH_LOAD = 8'(MATCH_SECONDS);

   logic                tick_live;
   logic [7:0]          time_q;
   logic [SHADOW_W-1:0] next_a, next_b;

   // The clock runs through PLAY (unpaused) and HOLD; expiry is judged on post-goal scores.
   assign tick_live   = io.tick_1hz & (play_live | (state_q == ST_HOLD));
   assign expire      = tick_live & (time_q == 8'd1);
   assign next_a      = count_a + SHADOW_W'(credit_a);
   assign next_b      = count_b + SHADOW_W'(credit_b);
   assign time_winner = (next_a > next_b) ? WIN_A :
                        (next_b > next_a) ? WIN_B : WIN_DRAW;
   assign io.time_left = time_q;

   // Load on match start, count down on live ticks, stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_q <= '0;
      end else if (start_acc) begin
         time_q <= MATCH_LOAD;
      end else if (tick_live && (time_q != 8'd0)) begin
         time_q <= time_q - 8'd1;
      end
   end
`else
   logic unused_tick;

   assign unused_tick  = io.tick_1hz;
   assign expire       = 1'b0;
   assign time_winner  = WIN_NONE;
   assign io.time_left = '0;
`endif

   // Input history for rising-edge detection; updated in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q  <= 1'b0;
         goal_a_q <= 1'b0;
         goal_b_q <= 1'b0;
      end else begin
         start_q  <= io.start;
         goal_a_q <= io.goal_a;
         goal_b_q <= io.goal_b;
      end
   end

   // Match FSM: a WIN_SCORE win beats timer expiry, which beats the post-goal HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         winner_q   <= WIN_NONE;
         flash_q    <= 1'b0;
         serve_q    <= 1'b0;
         prio_b_q   <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_OVER: begin
               if (start_ev) begin
                  state_q  <= ST_PLAY;
                  winner_q <= WIN_NONE;
                  serve_q  <= 1'b0;
                  prio_b_q <= 1'b0;
                  flash_q  <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (both_ev) prio_b_q <= ~prio_b_q;
               if (credit_a | credit_b) serve_q <= credit_a;
               if (win_a) begin
                  state_q  <= ST_OVER;
                  winner_q <= WIN_A;
               end else if (win_b) begin
                  state_q  <= ST_OVER;
                  winner_q <= WIN_B;
               end else if (expire) begin
                  state_q  <= ST_OVER;
                  winner_q <= time_winner;
               end else if (credit_a | credit_b) begin
                  state_q    <= ST_HOLD;
                  flash_q    <= 1'b1;
                  hold_cnt_q <= HOLD_LOAD;
               end
            end
            ST_HOLD: begin
               if (expire) begin
                  state_q  <= ST_OVER;
                  winner_q <= time_winner;
                  flash_q  <= 1'b0;
               end else if (hold_cnt_q == '0) begin
                  state_q <= ST_PLAY;
                  flash_q <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
               end
            end
         endcase
      end
   end

   assign io.state      = state_q;
   assign io.winner     = winner_q;
   assign io.goal_flash = flash_q;
   assign io.serve_side = serve_q;

   bcd_score_counter u_score_a (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_scores),
      .inc   (credit_a),
      .ones  (io.score_a_ones),
      .tens  (io.score_a_tens),
      .count (count_a)
   );

   bcd_score_counter u_score_b (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_scores),
      .inc   (credit_b),
      .ones  (io.score_b_ones),
      .tens  (io.score_b_tens),
      .count (count_b)
   );

endmodule
